// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//
// Two-stage pipelined carry-lookahead adder/subtractor. It uses two-level
// lookahead over BLOCK-bit groups, and has valid/ready handshakes on both
// sides.
//
// Stage 1 registers the per-bit generate and propagate terms and the
// effective carry-in. Subtraction is done as a + ~b + 1.
//
// Stage 2 registers:
//   - the sum;
//   - the full carry vector, where carry[i] is the carry out of bit i;
//   - the optional overflow flag.
// The group carries come from lookahead across all groups, with no ripple
// between groups. Inside each group, the per-bit carries come from lookahead
// from the group carry-in.
//
// Optional feature: define CLA_OVF_EN to add the `ovf` port. The flag is the
// signed overflow, carry[WIDTH-1] ^ carry[WIDTH-2].
//
// Parameters:
//   WIDTH      operand width. It must be a multiple of BLOCK and at least
//              BLOCK, with WIDTH >= 2.
//   BLOCK      lookahead group size in bits.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears the valid bits and all
//              data registers
//   in_valid   operands valid
//   in_ready   operands accepted this cycle (when in_valid is also high)
//   a, b       operands
//   cin        carry-in; ignored when sub=1
//   sub        1: compute a - b
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        result bits (modulo 2^WIDTH)
//   carry      per-bit carry-out vector
//   cout       carry[WIDTH-1]; in subtract mode 1 means no borrow
//   ovf        signed overflow (only with CLA_OVF_EN)
//
// Handshake:
//   A transfer happens on a rising edge where valid && ready on that side.
//   A producer holds valid and its data stable until the transfer happens.
//   out_valid and the result registers only change on an output transfer or
//   a stage advance. in_ready depends combinationally on out_ready.
//   out_valid never depends on in_valid.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NGRP = WIDTH / BLOCK;

    // Stage 1 state
    logic             v1;
    logic [WIDTH-1:0] g1;
    logic [WIDTH-1:0] p1;
    logic             c0_1;

    // Stage 2 state
    logic v2;

    // Handshake control
    logic s2_adv;
    logic in_xfer;

    assign s2_adv    = v1 && (!v2 || out_ready);
    assign in_ready  = !v1 || s2_adv;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = v2;

    // Stage 1 input conditioning
    logic [WIDTH-1:0] b_eff;
    logic             c0_in;

    assign b_eff = sub ? ~b : b;
    assign c0_in = sub ? 1'b1 : cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            g1   <= '0;
            p1   <= '0;
            c0_1 <= 1'b0;
        end else begin
            if (in_xfer) begin
                v1   <= 1'b1;
                g1   <= a & b_eff;
                p1   <= a ^ b_eff;
                c0_1 <= c0_in;
            end else if (s2_adv) begin
                // S1 drained into S2 with nothing new behind it
                v1 <= 1'b0;
            end
        end
    end

    // Two-level lookahead
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP-1:0]  grp_cin;
    logic [WIDTH-1:0] carry_nxt;
    logic [WIDTH-1:0] sum_nxt;

    always_comb begin
        logic term;
        grp_g     = '0;
        grp_p     = '0;
        grp_cin   = '0;
        carry_nxt = '0;
        term      = 1'b0;

        // Group generate/propagate: G = g[n-1] | p[n-1]g[n-2] | ... flattened
        for (int j = 0; j < NGRP; j++) begin
            grp_p[j] = &p1[j*BLOCK +: BLOCK];
            for (int k = 0; k < BLOCK; k++) begin
                term = g1[j*BLOCK + k];
                for (int m = k + 1; m < BLOCK; m++) begin
                    term &= p1[j*BLOCK + m];
                end
                grp_g[j] |= term;
            end
        end

        // Group carry-ins. Each one is a flat sum of products over all lower
        // groups plus c0, so no group waits on its neighbour's carry.
        for (int j = 0; j < NGRP; j++) begin
            term = c0_1;
            for (int m = 0; m < j; m++) begin
                term &= grp_p[m];
            end
            grp_cin[j] = term;
            for (int k = 0; k < j; k++) begin
                term = grp_g[k];
                for (int m = k + 1; m < j; m++) begin
                    term &= grp_p[m];
                end
                grp_cin[j] |= term;
            end
        end

        // Per-bit carry-outs inside each group, by lookahead from the group
        // carry-in
        for (int j = 0; j < NGRP; j++) begin
            for (int i = 0; i < BLOCK; i++) begin
                term = grp_cin[j];
                for (int m = 0; m <= i; m++) begin
                    term &= p1[j*BLOCK + m];
                end
                carry_nxt[j*BLOCK + i] = term;
                for (int k = 0; k <= i; k++) begin
                    term = g1[j*BLOCK + k];
                    for (int m = k + 1; m <= i; m++) begin
                        term &= p1[j*BLOCK + m];
                    end
                    carry_nxt[j*BLOCK + i] |= term;
                end
            end
        end
    end

    assign sum_nxt = p1 ^ {carry_nxt[WIDTH-2:0], c0_1};

    // Stage 2 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            sum   <= '0;
            carry <= '0;
        end else begin
            if (s2_adv) begin
                v2    <= 1'b1;
                sum   <= sum_nxt;
                carry <= carry_nxt;
            end else if (out_ready) begin
                // Result consumed and nothing moves up behind it
                v2 <= 1'b0;
            end
        end
    end

    assign cout = carry[WIDTH-1];

`ifdef CLA_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (s2_adv) begin
            ovf <= carry_nxt[WIDTH-1] ^ carry_nxt[WIDTH-2];
        end
    end
`endif

endmodule
